// File: rtl/cache_control.sv
// Control FSM for the 2-way write-back cache: hits answer the CPU in the cycle they are presented; misses run write-back/allocate.
// Backpressure: the CPU holds its request until cpu_resp, and memory phases wait for mem_resp.
// The optional saturating hit/miss/write-back counters are built only when CACHE_CTRL_PERF_EN is defined.
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    output logic                 cpu_resp,
    input  logic                 hit0,
    input  logic                 hit1,
    input  logic                 lru_out,
    input  logic                 dir0_out,
    input  logic                 dir1_out,
    input  logic                 mem_resp,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 indata_muxsel,
    output logic                 outdata_muxsel,
    output logic [1:0]           memaddr_muxsel,
    output logic                 lru_we,
    output logic                 lru_in,
    output logic                 val_in,
    output logic                 dir_in,
    output logic                 write0,
    output logic                 write1,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} state_t;

    state_t state;
    logic   victim;

    logic req, hit, hit_way, victim_dirty, miss_evt, wb_exit;

    assign req          = cpu_read | cpu_write;
    assign hit          = hit0 | hit1;
    assign hit_way      = hit1 & ~hit0;
    assign victim_dirty = lru_out ? dir1_out : dir0_out;
    assign miss_evt     = (state == CHECK) && req && !hit;
    assign wb_exit      = (state == WRITEBACK) && mem_resp;

    // Outputs are gated by rst so an in-flight memory request drops immediately.
    always_comb begin
        cpu_resp       = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        indata_muxsel  = 1'b0;
        outdata_muxsel = 1'b0;
        memaddr_muxsel = 2'd0;
        lru_we         = 1'b0;
        lru_in         = 1'b0;
        val_in         = 1'b0;
        dir_in         = 1'b0;
        write0         = 1'b0;
        write1         = 1'b0;
        if (!rst) begin
            case (state)
                CHECK: begin
                    if (req && hit) begin
                        cpu_resp       = 1'b1;
                        outdata_muxsel = hit_way;
                        lru_we         = 1'b1;
                        lru_in         = ~hit_way;
                        if (cpu_write) begin
                            indata_muxsel = 1'b1;
                            write0        = ~hit_way;
                            write1        = hit_way;
                            val_in        = 1'b1;
                            dir_in        = 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    mem_write      = 1'b1;
                    outdata_muxsel = victim;
                    memaddr_muxsel = victim ? 2'd2 : 2'd1;
                end
                ALLOCATE: begin
                    mem_read = 1'b1;
                    if (mem_resp) begin
                        write0 = ~victim;
                        write1 = victim;
                        val_in = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CHECK;
            victim <= 1'b0;
        end else begin
            case (state)
                CHECK: begin
                    if (miss_evt) begin
                        victim <= lru_out;
                        state  <= victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: if (mem_resp) state <= ALLOCATE;
                ALLOCATE:  if (mem_resp) state <= CHECK;
                default:   state <= CHECK;
            endcase
        end
    end

`ifdef CACHE_CTRL_PERF_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (cpu_resp && hit_count != CNT_MAX)
                hit_count <= hit_count + 1'b1;
            if (miss_evt && miss_count != CNT_MAX)
                miss_count <= miss_count + 1'b1;
            if (wb_exit && wb_count != CNT_MAX)
                wb_count <= wb_count + 1'b1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule
